// File: rtl/e203_exu_bjp_rslv.sv
// BJP commit resolver: decides on front-end flushes, registers the redirect PC/cause
// and holds the flush request until the IFU acknowledges it; keeps saturating statistics.
module e203_exu_bjp_rslv #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmt_i_valid,
  output logic             cmt_i_ready,
  input  logic             cmt_i_bjp,
  input  logic             cmt_i_mret,
  input  logic             cmt_i_dret,
  input  logic             cmt_i_fencei,
  input  logic             cmt_i_prdt,
  input  logic             cmt_i_rslv,
  input  logic [PC_W-1:0]  cmt_i_pc,
  input  logic             cmt_i_rv32,
  input  logic [PC_W-1:0]  cmt_i_tgt,
  input  logic [PC_W-1:0]  csr_epc,
  input  logic [PC_W-1:0]  csr_dpc,
  output logic             flush_req,
  input  logic             flush_ack,
  output logic [PC_W-1:0]  flush_pc,
  output logic [2:0]       flush_cause,
  output logic             retire_o,
  output logic [CNT_W-1:0] bjp_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  input  logic             cnt_clr
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t state_q, state_d;

  logic             accept_p0;
  logic             mispred_p0;
  logic             need_flush_p0;
  logic             vld_p1;
  logic [PC_W-1:0]  flush_pc_p1;
  logic [2:0]       flush_cause_p1;
  logic [CNT_W-1:0] bjp_cnt_p1;
  logic [CNT_W-1:0] mispred_cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Priority dret > mret > fence.i > mispredict; sequential PC wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] redirect_pc(
    input logic            dret,
    input logic            mret,
    input logic            fencei,
    input logic            rslv,
    input logic            rv32,
    input logic [PC_W-1:0] pc,
    input logic [PC_W-1:0] tgt,
    input logic [PC_W-1:0] epc,
    input logic [PC_W-1:0] dpc
  );
    logic [PC_W-1:0] seq_pc;
    seq_pc = pc + (rv32 ? PC_W'(4) : PC_W'(2));
    if (dret)        return dpc;
    else if (mret)   return epc;
    else if (fencei) return seq_pc;
    else if (rslv)   return tgt;
    else             return seq_pc;
  endfunction

  function automatic logic [2:0] redirect_cause(input logic dret, input logic mret);
    if (dret)      return 3'b100;
    else if (mret) return 3'b010;
    else           return 3'b001;
  endfunction

  // Stage p0: handshake and flush decision on the incoming commit
  assign cmt_i_ready   = (state_q == IDLE);
  assign accept_p0     = cmt_i_valid & cmt_i_ready;
  assign mispred_p0    = cmt_i_bjp & (cmt_i_prdt ^ cmt_i_rslv);
  assign need_flush_p0 = cmt_i_dret | cmt_i_mret | cmt_i_fencei | mispred_p0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_p0 && need_flush_p0) state_d = FLUSH;
      FLUSH:   if (flush_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Stage p1: redirect payload captured at accept, frozen while the request is pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1         <= 1'b0;
      flush_pc_p1    <= '0;
      flush_cause_p1 <= '0;
    end else begin
      vld_p1 <= accept_p0;
      if (accept_p0 && need_flush_p0) begin
        flush_pc_p1    <= redirect_pc(cmt_i_dret, cmt_i_mret, cmt_i_fencei, cmt_i_rslv,
                                      cmt_i_rv32, cmt_i_pc, cmt_i_tgt, csr_epc, csr_dpc);
        flush_cause_p1 <= redirect_cause(cmt_i_dret, cmt_i_mret);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bjp_cnt_p1     <= '0;
      mispred_cnt_p1 <= '0;
    end else if (cnt_clr) begin
      bjp_cnt_p1     <= '0;
      mispred_cnt_p1 <= '0;
    end else if (accept_p0 && cmt_i_bjp) begin
      bjp_cnt_p1 <= sat_inc(bjp_cnt_p1);
      if (mispred_p0) mispred_cnt_p1 <= sat_inc(mispred_cnt_p1);
    end
  end

  assign flush_req   = (state_q == FLUSH);
  assign flush_pc    = flush_pc_p1;
  assign flush_cause = flush_cause_p1;
  assign retire_o    = vld_p1;
  assign bjp_cnt     = bjp_cnt_p1;
  assign mispred_cnt = mispred_cnt_p1;

endmodule

// File: tb/tb_e203_exu_bjp_rslv.sv
// Bench for e203_exu_bjp_rslv: directed table, hand-written corner sequences and a
// randomized phase checked against a behavioural model of the commit/redirect rules.
module tb_e203_exu_bjp_rslv;
  localparam int PC_W  = 32;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmt_i_valid, cmt_i_ready;
  logic             cmt_i_bjp, cmt_i_mret, cmt_i_dret, cmt_i_fencei;
  logic             cmt_i_prdt, cmt_i_rslv, cmt_i_rv32;
  logic [PC_W-1:0]  cmt_i_pc, cmt_i_tgt, csr_epc, csr_dpc;
  logic             flush_req, flush_ack;
  logic [PC_W-1:0]  flush_pc;
  logic [2:0]       flush_cause;
  logic             retire_o;
  logic [CNT_W-1:0] bjp_cnt, mispred_cnt;
  logic             cnt_clr;

  int n_vec = 0;
  int n_err = 0;

  e203_exu_bjp_rslv #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmt_i_valid(cmt_i_valid), .cmt_i_ready(cmt_i_ready),
    .cmt_i_bjp(cmt_i_bjp), .cmt_i_mret(cmt_i_mret), .cmt_i_dret(cmt_i_dret),
    .cmt_i_fencei(cmt_i_fencei), .cmt_i_prdt(cmt_i_prdt), .cmt_i_rslv(cmt_i_rslv),
    .cmt_i_pc(cmt_i_pc), .cmt_i_rv32(cmt_i_rv32), .cmt_i_tgt(cmt_i_tgt),
    .csr_epc(csr_epc), .csr_dpc(csr_dpc),
    .flush_req(flush_req), .flush_ack(flush_ack), .flush_pc(flush_pc),
    .flush_cause(flush_cause), .retire_o(retire_o),
    .bjp_cnt(bjp_cnt), .mispred_cnt(mispred_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bjp, mret, dret, fencei, prdt, rslv, rv32;
    logic [31:0] pc, tgt, epc, dpc;
    logic        e_flush;
    logic [31:0] e_pc;
    logic [2:0]  e_cause;
    int          e_bjp, e_mis;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmt();
    cmt_i_valid = 0; cmt_i_bjp = 0; cmt_i_mret = 0; cmt_i_dret = 0; cmt_i_fencei = 0;
    cmt_i_prdt = 0; cmt_i_rslv = 0; cmt_i_rv32 = 1;
    cmt_i_pc = '0; cmt_i_tgt = '0; csr_epc = '0; csr_dpc = '0;
  endtask

  task automatic drive(input vec_t v);
    cmt_i_valid = 1; cmt_i_bjp = v.bjp; cmt_i_mret = v.mret; cmt_i_dret = v.dret;
    cmt_i_fencei = v.fencei; cmt_i_prdt = v.prdt; cmt_i_rslv = v.rslv; cmt_i_rv32 = v.rv32;
    cmt_i_pc = v.pc; cmt_i_tgt = v.tgt; csr_epc = v.epc; csr_dpc = v.dpc;
  endtask

  task automatic mispredict(input logic [31:0] tgt);
    clear_cmt();
    cmt_i_valid = 1; cmt_i_bjp = 1; cmt_i_prdt = 0; cmt_i_rslv = 1;
    cmt_i_pc = 32'h1234; cmt_i_tgt = tgt;
  endtask

  // Behavioural reference state for the random phase
  bit          m_busy, m_retire;
  logic [31:0] m_pc;
  logic [2:0]  m_cause;
  int          m_bjp, m_mis;

  task automatic model_step();
    bit          acc, mis, fl;
    logic [31:0] seq;
    acc = cmt_i_valid && !m_busy;
    mis = cmt_i_bjp && (cmt_i_prdt != cmt_i_rslv);
    fl  = cmt_i_dret || cmt_i_mret || cmt_i_fencei || mis;
    seq = cmt_i_pc + (cmt_i_rv32 ? 32'd4 : 32'd2);
    m_retire = acc;
    if (m_busy) begin
      if (flush_ack) m_busy = 0;
    end else if (acc && fl) begin
      m_busy = 1;
      if (cmt_i_dret)        begin m_pc = csr_dpc; m_cause = 3'b100; end
      else if (cmt_i_mret)   begin m_pc = csr_epc; m_cause = 3'b010; end
      else if (cmt_i_fencei) begin m_pc = seq;     m_cause = 3'b001; end
      else                   begin m_pc = cmt_i_rslv ? cmt_i_tgt : seq; m_cause = 3'b001; end
    end
    if (cnt_clr) begin
      m_bjp = 0; m_mis = 0;
    end else if (acc && cmt_i_bjp) begin
      m_bjp = (m_bjp < CMAX) ? m_bjp + 1 : CMAX;
      if (mis) m_mis = (m_mis < CMAX) ? m_mis + 1 : CMAX;
    end
  endtask

  initial begin
    //                bjp mret dret fi prdt rslv rv32 pc            tgt           epc    dpc     fl e_pc          cause   b  m
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100,      32'h5554, 32'h0,  32'h0,   1'b0, 32'h0,    3'b000, 1, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0FFE,     32'h7770, 32'h0,  32'h0,   1'b1, 32'h1000, 3'b001, 2, 1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40,       32'h0,    32'h80, 32'h900, 1'b1, 32'h80,   3'b010, 2, 1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40,       32'h0,    32'h80, 32'h300, 1'b1, 32'h300,  3'b100, 2, 1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 32'h0,    32'h0,  32'h0,   1'b1, 32'h2,    3'b001, 2, 1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h500,      32'h2000, 32'h0,  32'h0,   1'b1, 32'h2000, 3'b001, 3, 2};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600,      32'h9990, 32'h0,  32'h0,   1'b0, 32'h0,    3'b000, 4, 2};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h700,      32'h0,    32'h0,  32'h0,   1'b0, 32'h0,    3'b000, 4, 2};

    clear_cmt();
    flush_ack = 0; cnt_clr = 0; rst = 1;
    repeat (2) tick();
    rst = 0;
    tick();

    chk("reset_flush_req", 32'(flush_req), 0);
    chk("reset_flush_pc", flush_pc, 0);
    chk("reset_flush_cause", 32'(flush_cause), 0);
    chk("reset_retire", 32'(retire_o), 0);
    chk("reset_bjp_cnt", 32'(bjp_cnt), 0);
    chk("reset_mispred_cnt", 32'(mispred_cnt), 0);
    chk("reset_ready", 32'(cmt_i_ready), 1);

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i]);
      tick();
      cmt_i_valid = 0;
      chk($sformatf("tbl%0d_retire", i), 32'(retire_o), 1);
      chk($sformatf("tbl%0d_flush_req", i), 32'(flush_req), 32'(tbl[i].e_flush));
      chk($sformatf("tbl%0d_bjp_cnt", i), 32'(bjp_cnt), tbl[i].e_bjp);
      chk($sformatf("tbl%0d_mispred_cnt", i), 32'(mispred_cnt), tbl[i].e_mis);
      if (tbl[i].e_flush) begin
        chk($sformatf("tbl%0d_flush_pc", i), flush_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_cause", i), 32'(flush_cause), 32'(tbl[i].e_cause));
        chk($sformatf("tbl%0d_ready_busy", i), 32'(cmt_i_ready), 0);
        flush_ack = 1;
        tick();
        flush_ack = 0;
        chk($sformatf("tbl%0d_req_drop", i), 32'(flush_req), 0);
        chk($sformatf("tbl%0d_retire_drop", i), 32'(retire_o), 0);
      end
      chk($sformatf("tbl%0d_ready", i), 32'(cmt_i_ready), 1);
    end

    // Redirect held stable across a 3-cycle ack stall, then immediate next accept
    mispredict(32'h2000);
    tick();
    clear_cmt();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall%0d_req", k), 32'(flush_req), 1);
      chk($sformatf("stall%0d_pc", k), flush_pc, 32'h2000);
      chk($sformatf("stall%0d_ready", k), 32'(cmt_i_ready), 0);
      if (k == 3) flush_ack = 1;
      tick();
    end
    flush_ack = 0;
    chk("stall_req_drop", 32'(flush_req), 0);
    chk("stall_ready_back", 32'(cmt_i_ready), 1);
    cmt_i_valid = 1; cmt_i_bjp = 1; cmt_i_prdt = 1; cmt_i_rslv = 1;
    tick();
    clear_cmt();
    chk("after_flush_accept", 32'(retire_o), 1);
    chk("after_flush_no_req", 32'(flush_req), 0);

    // An ack seen while idle must not cancel the next redirect
    flush_ack = 1;
    tick();
    mispredict(32'h3000);
    tick();
    clear_cmt();
    chk("idle_ack_req", 32'(flush_req), 1);
    chk("idle_ack_pc", flush_pc, 32'h3000);
    tick();
    chk("idle_ack_drop", 32'(flush_req), 0);
    flush_ack = 0;

    // Saturation of both counters, then clear winning over an accept
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    chk("clr_bjp", 32'(bjp_cnt), 0);
    chk("clr_mis", 32'(mispred_cnt), 0);
    flush_ack = 1;
    mispredict(32'h40);
    repeat (2 * (CMAX + 5)) tick();
    clear_cmt();
    repeat (2) tick();
    chk("sat_bjp", 32'(bjp_cnt), CMAX);
    chk("sat_mis", 32'(mispred_cnt), CMAX);
    mispredict(32'h44);
    tick();
    clear_cmt();
    chk("sat_hold_bjp", 32'(bjp_cnt), CMAX);
    chk("sat_hold_mis", 32'(mispred_cnt), CMAX);
    tick();
    chk("sat_ready", 32'(cmt_i_ready), 1);
    mispredict(32'h48);
    cnt_clr = 1;
    tick();
    clear_cmt();
    cnt_clr = 0;
    chk("clr_vs_inc_bjp", 32'(bjp_cnt), 0);
    chk("clr_vs_inc_mis", 32'(mispred_cnt), 0);
    tick();
    flush_ack = 0;

    // Asynchronous reset in the middle of a pending redirect
    mispredict(32'h5000);
    tick();
    clear_cmt();
    chk("pre_rst_req", 32'(flush_req), 1);
    #2 rst = 1;
    #1;
    chk("async_rst_req", 32'(flush_req), 0);
    chk("async_rst_pc", flush_pc, 0);
    chk("async_rst_bjp", 32'(bjp_cnt), 0);
    tick();
    rst = 0;
    tick();
    chk("post_rst_ready", 32'(cmt_i_ready), 1);
    chk("post_rst_req", 32'(flush_req), 0);

    // Randomized traffic against the reference model
    m_busy = 0; m_retire = 0; m_pc = '0; m_cause = '0; m_bjp = 0; m_mis = 0;
    for (int n = 0; n < 3000; n++) begin
      cmt_i_valid  = ($urandom_range(9) < 7);
      cmt_i_bjp    = $urandom_range(1);
      cmt_i_mret   = ($urandom_range(7) == 0);
      cmt_i_dret   = ($urandom_range(7) == 0);
      cmt_i_fencei = ($urandom_range(7) == 0);
      cmt_i_prdt   = $urandom_range(1);
      cmt_i_rslv   = $urandom_range(1);
      cmt_i_rv32   = $urandom_range(1);
      cmt_i_pc     = ($urandom_range(15) == 0) ? 32'hFFFFFFFE : $urandom;
      cmt_i_tgt    = $urandom;
      csr_epc      = $urandom;
      csr_dpc      = $urandom;
      flush_ack    = $urandom_range(1);
      cnt_clr      = ($urandom_range(31) == 0);
      model_step();
      tick();
      chk("rnd_ready", 32'(cmt_i_ready), 32'(!m_busy));
      chk("rnd_req", 32'(flush_req), 32'(m_busy));
      chk("rnd_retire", 32'(retire_o), 32'(m_retire));
      chk("rnd_bjp", 32'(bjp_cnt), m_bjp);
      chk("rnd_mis", 32'(mispred_cnt), m_mis);
      if (m_busy) begin
        chk("rnd_pc", flush_pc, m_pc);
        chk("rnd_cause", 32'(flush_cause), 32'(m_cause));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
